lap_controller: RTL and testbench
=================================

# lap_controller

Sequencing controller for the stopwatch mm:ss datapath. It adds run/pause control, a lap buffer holding up to four captured times, and lap recall. It sits between the debouncers/clock divider and the seven-segment display driver: it consumes one-cycle enable pulses and drives the min/sec values and the blink enables the display shows.

## Interface
- LAPS, 4: lap buffer depth (2..8)
- MAX_MIN, 59: highest minute value before wrap
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- tick  input  1  one-cycle 1 Hz count enable from the clock divider
- start_stop  input  1  one-cycle debounced pulse; toggles run/pause
- lap  input  1  one-cycle debounced pulse; captures live time while running
- recall  input  1  one-cycle debounced pulse; steps through stored laps while paused
- clear  input  1  one-cycle debounced pulse; returns to idle while paused/recalling
- min  output  6  displayed minutes, 0..MAX_MIN
- sec  output  6  displayed seconds, 0..59
- running  output  1  1 while in RUN
- showing_lap  output  1  1 while in RECALL
- lap_idx  output  clog2(LAPS)  index of the lap shown in RECALL, else 0
- lap_count  output  clog2(LAPS)+1  number of stored laps
- lap_full  output  1  lap_count == LAPS
- blink_en  output  2  bit0 blinks the minute digits, bit1 blinks the second digits

## Operation
- Live counter: lmin/lsec registers. In RUN, tick increments lsec. lsec 59 -> 0 with lmin+1. At MAX_MIN:59 the next tick wraps to 00:00. No saturation.
- FSM states: IDLE, RUN, PAUSE, RECALL.
- IDLE: live = 00:00, lap_count = 0. start_stop -> RUN. All other inputs are ignored.
- RUN:
  - start_stop -> PAUSE.
  - lap with lap_count < LAPS writes the live value into slot lap_count, then lap_count+1. lap when full is ignored (no overwrite).
  - recall and clear are ignored.
- PAUSE:
  - start_stop -> RUN.
  - recall with lap_count > 0 -> RECALL, lap_idx = 0. recall with lap_count = 0 is ignored.
  - clear -> IDLE: live and lap_count are zeroed. Buffer contents need not be zeroed but are never displayed.
  - lap is ignored.
- RECALL:
  - recall with lap_idx < lap_count-1 increments lap_idx. recall at lap_idx = lap_count-1 -> PAUSE, lap_idx = 0.
  - start_stop -> RUN, lap_idx = 0.
  - clear -> IDLE.
  - lap is ignored. The live counter holds.
- Display mux: min/sec = stored lap[lap_idx] in RECALL, otherwise the live value.
- blink_en:
  - IDLE and RUN: 2'b00
  - PAUSE: 2'b11
  - RECALL: 2'b01 (minutes blink, marking a lap view)
- Simultaneous pulses are resolved by priority clear > start_stop > lap > recall. Only the highest-priority pulse that is legal in the current state acts; the rest are dropped.
- A lap captured in the same cycle as a tick stores the pre-increment value.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert use):
  - state IDLE
  - min = sec = 0
  - running = showing_lap = 0
  - lap_idx = lap_count = 0, lap_full = 0
  - blink_en = 0
- All outputs are registered and update on the rising edge that samples the causing pulse. Latency is 1 clk from the pulse to the output.
- A tick in the edge that leaves RUN (start_stop) is still counted. A tick in the edge that enters RUN is not counted.
- Each pulse is assumed high for exactly 1 clk. A pulse held high acts once per cycle; no internal edge detection.
- Reset asserted mid-count or mid-recall aborts immediately. No lap is retained.

## Test plan
- Reset, start_stop, 61 ticks -> min=1, sec=1, running=1, blink_en=00.
- Preload live to 59:59 via ticks, 1 tick -> 00:00, state remains RUN.
- In RUN, lap at 00:05, 00:12, 00:20, 00:33, 00:40 -> lap_count=4, lap_full=1, fifth capture dropped. Then start_stop -> PAUSE, blink_en=11.
- In PAUSE, recall x4:
  - displays 00:05/00:12/00:20/00:33 with lap_idx 0..3, showing_lap=1, blink_en=01.
  - 5th recall -> PAUSE, display returns to the live value.
- Same-cycle start_stop+clear in PAUSE -> IDLE, 00:00, lap_count=0. Same-cycle tick+lap in RUN at 00:07 -> stored 00:07, live 00:08.
- reset pulled low during RECALL -> all outputs 0 asynchronously. After release, tick alone does not count (IDLE).

Source files
------------

// File: rtl/lap_controller_if.sv
// Control pulses in, display values and status out, between the stopwatch
// front end and the lap_controller sequencer.
interface lap_controller_if #(
  parameter int unsigned LAPS = 4
);
  logic                        tick;
  logic                        start_stop;
  logic                        lap;
  logic                        recall;
  logic                        clear;
  logic [5:0]                  min;
  logic [5:0]                  sec;
  logic                        running;
  logic                        showing_lap;
  logic [$clog2(LAPS)-1:0]     lap_idx;
  logic [$clog2(LAPS):0]       lap_count;
  logic                        lap_full;
  logic [1:0]                  blink_en;

  modport master (
    output tick, start_stop, lap, recall, clear,
    input  min, sec, running, showing_lap, lap_idx, lap_count, lap_full, blink_en
  );

  modport slave (
    input  tick, start_stop, lap, recall, clear,
    output min, sec, running, showing_lap, lap_idx, lap_count, lap_full, blink_en
  );
endinterface

// File: rtl/lap_controller.sv
// Stopwatch sequencer: run/pause control of the mm:ss live counter, a small
// lap buffer, and lap recall feeding the display with registered outputs.
module lap_controller #(
  parameter int unsigned LAPS    = 4,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic             clk,
  input  logic             reset,
  lap_controller_if.slave  bus
);
  localparam int unsigned IW = $clog2(LAPS);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_RECALL} state_t;

  state_t          r_state;
  logic [5:0]      r_lmin, r_lsec;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [5:0]      r_lap_min [LAPS];
  logic [5:0]      r_lap_sec [LAPS];

  state_t          w_state_n;
  logic [5:0]      w_lmin_n, w_lsec_n;
  logic [CW-1:0]   w_cnt_n;
  logic [IW-1:0]   w_idx_n;
  logic            w_lap_we;

  // Each branch walks the pulses in priority order and only accepts one that
  // is legal in the current state, so an illegal higher pulse never masks a legal lower one.
  always_comb begin
    w_state_n = r_state;
    w_lmin_n  = r_lmin;
    w_lsec_n  = r_lsec;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_lap_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_stop) w_state_n = S_RUN;
      end
      S_RUN: begin
        if (bus.tick) begin
          if (r_lsec == 6'd59) begin
            w_lsec_n = '0;
            w_lmin_n = (r_lmin == 6'(MAX_MIN)) ? '0 : r_lmin + 6'd1;
          end else begin
            w_lsec_n = r_lsec + 6'd1;
          end
        end
        if (bus.start_stop) begin
          w_state_n = S_PAUSE;
        end else if (bus.lap && (r_cnt < CW'(LAPS))) begin
          w_lap_we = 1'b1;
          w_cnt_n  = r_cnt + 1'b1;
        end
      end
      S_PAUSE: begin
        if (bus.clear) begin
          w_state_n = S_IDLE;
          w_lmin_n  = '0;
          w_lsec_n  = '0;
          w_cnt_n   = '0;
        end else if (bus.start_stop) begin
          w_state_n = S_RUN;
        end else if (bus.recall && (r_cnt != '0)) begin
          w_state_n = S_RECALL;
          w_idx_n   = '0;
        end
      end
      S_RECALL: begin
        if (bus.clear) begin
          w_state_n = S_IDLE;
          w_lmin_n  = '0;
          w_lsec_n  = '0;
          w_cnt_n   = '0;
          w_idx_n   = '0;
        end else if (bus.start_stop) begin
          w_state_n = S_RUN;
          w_idx_n   = '0;
        end else if (bus.recall) begin
          if ((CW'(r_idx) + 1'b1) < r_cnt) begin
            w_idx_n = r_idx + 1'b1;
          end else begin
            w_state_n = S_PAUSE;
            w_idx_n   = '0;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_lmin          <= '0;
      r_lsec          <= '0;
      r_cnt           <= '0;
      r_idx           <= '0;
      bus.min         <= '0;
      bus.sec         <= '0;
      bus.running     <= 1'b0;
      bus.showing_lap <= 1'b0;
      bus.lap_idx     <= '0;
      bus.lap_count   <= '0;
      bus.lap_full    <= 1'b0;
      bus.blink_en    <= '0;
    end else begin
      r_state <= w_state_n;
      r_lmin  <= w_lmin_n;
      r_lsec  <= w_lsec_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      // Outputs are derived from next-state values to give 1-clk pulse-to-display latency.
      bus.min         <= (w_state_n == S_RECALL) ? r_lap_min[w_idx_n] : w_lmin_n;
      bus.sec         <= (w_state_n == S_RECALL) ? r_lap_sec[w_idx_n] : w_lsec_n;
      bus.running     <= (w_state_n == S_RUN);
      bus.showing_lap <= (w_state_n == S_RECALL);
      bus.lap_idx     <= w_idx_n;
      bus.lap_count   <= w_cnt_n;
      bus.lap_full    <= (w_cnt_n == CW'(LAPS));
      case (w_state_n)
        S_PAUSE:  bus.blink_en <= 2'b11;
        S_RECALL: bus.blink_en <= 2'b01;
        default:  bus.blink_en <= 2'b00;
      endcase
    end
  end

  // Buffer holds data only; it is not reset since cleared slots are never displayed.
  always_ff @(posedge clk) begin
    if (w_lap_we) begin
      r_lap_min[r_cnt[IW-1:0]] <= r_lmin;
      r_lap_sec[r_cnt[IW-1:0]] <= r_lsec;
    end
  end
endmodule

// File: tb/tb_lap_controller.sv
// Directed bench for lap_controller: run/pause, wrap, lap capture, recall,
// pulse priority and asynchronous reset.
module tb_lap_controller;
  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  lap_controller_if #(.LAPS(4)) bus_if ();

  lap_controller #(.LAPS(4), .MAX_MIN(59)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses high; returns 1 time unit after the edge.
  task automatic cyc(input logic tk, input logic ss, input logic lp,
                     input logic rc, input logic cl);
    @(negedge clk);
    bus_if.tick = tk; bus_if.start_stop = ss; bus_if.lap = lp;
    bus_if.recall = rc; bus_if.clear = cl;
    @(posedge clk);
    #1;
    bus_if.tick = 0; bus_if.start_stop = 0; bus_if.lap = 0;
    bus_if.recall = 0; bus_if.clear = 0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic chk_time(input string tag, input int unsigned m, input int unsigned s);
    check({tag, ".min"}, bus_if.min, m);
    check({tag, ".sec"}, bus_if.sec, s);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    bus_if.tick = 0; bus_if.start_stop = 0; bus_if.lap = 0;
    bus_if.recall = 0; bus_if.clear = 0;
    reset = 0;
    #23;
    chk_time("rst", 0, 0);
    check("rst.running", bus_if.running, 0);
    check("rst.showing", bus_if.showing_lap, 0);
    check("rst.idx", bus_if.lap_idx, 0);
    check("rst.count", bus_if.lap_count, 0);
    check("rst.full", bus_if.lap_full, 0);
    check("rst.blink", bus_if.blink_en, 0);
    @(negedge clk); reset = 1;

    // IDLE ignores ticks; entering RUN with a tick does not count it
    cyc(1, 0, 0, 0, 0);
    check("idle_tick.sec", bus_if.sec, 0);
    cyc(1, 1, 0, 0, 0);
    check("start.running", bus_if.running, 1);
    check("start.sec", bus_if.sec, 0);
    ticks(61);
    chk_time("61t", 1, 1);
    check("61t.running", bus_if.running, 1);
    check("61t.blink", bus_if.blink_en, 0);

    ticks(3599 - 61);
    chk_time("5959", 59, 59);
    ticks(1);
    chk_time("wrap", 0, 0);
    check("wrap.running", bus_if.running, 1);

    // Fill the lap buffer; the fifth capture is dropped
    ticks(5);  cyc(0, 0, 1, 0, 0);
    check("lap1.count", bus_if.lap_count, 1);
    ticks(7);  cyc(0, 0, 1, 0, 0);
    ticks(8);  cyc(0, 0, 1, 0, 0);
    ticks(13); cyc(0, 0, 1, 0, 0);
    check("lap4.count", bus_if.lap_count, 4);
    check("lap4.full", bus_if.lap_full, 1);
    ticks(7);  cyc(0, 0, 1, 0, 0);
    check("lap5.count", bus_if.lap_count, 4);
    chk_time("lap5.live", 0, 40);
    cyc(0, 1, 0, 0, 0);
    check("pause.blink", bus_if.blink_en, 3);
    check("pause.running", bus_if.running, 0);
    // Lap in PAUSE is ignored
    cyc(0, 0, 1, 0, 0);
    check("pause_lap.count", bus_if.lap_count, 4);

    cyc(0, 0, 0, 1, 0);
    chk_time("rc0", 0, 5);
    check("rc0.idx", bus_if.lap_idx, 0);
    check("rc0.showing", bus_if.showing_lap, 1);
    check("rc0.blink", bus_if.blink_en, 1);
    cyc(0, 0, 0, 1, 0);
    chk_time("rc1", 0, 12);
    check("rc1.idx", bus_if.lap_idx, 1);
    cyc(0, 0, 0, 1, 0);
    chk_time("rc2", 0, 20);
    check("rc2.idx", bus_if.lap_idx, 2);
    cyc(0, 0, 0, 1, 0);
    chk_time("rc3", 0, 33);
    check("rc3.idx", bus_if.lap_idx, 3);
    cyc(0, 0, 0, 1, 0);
    chk_time("rc4.live", 0, 40);
    check("rc4.showing", bus_if.showing_lap, 0);
    check("rc4.idx", bus_if.lap_idx, 0);
    check("rc4.blink", bus_if.blink_en, 3);

    // clear outranks start_stop
    cyc(0, 1, 0, 0, 1);
    chk_time("clr", 0, 0);
    check("clr.count", bus_if.lap_count, 0);
    check("clr.full", bus_if.lap_full, 0);
    check("clr.running", bus_if.running, 0);
    check("clr.blink", bus_if.blink_en, 0);

    // Recall with an empty buffer stays in PAUSE
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("rc_empty.showing", bus_if.showing_lap, 0);
    check("rc_empty.blink", bus_if.blink_en, 3);
    cyc(0, 1, 0, 0, 0);

    // Tick and lap together capture the pre-increment value
    ticks(7);
    chk_time("pre_lap", 0, 7);
    cyc(1, 0, 1, 0, 0);
    chk_time("ticklap.live", 0, 8);
    check("ticklap.count", bus_if.lap_count, 1);
    // Tick on the edge leaving RUN is still counted
    cyc(1, 1, 0, 0, 0);
    chk_time("leave_tick", 0, 9);
    check("leave_tick.running", bus_if.running, 0);
    cyc(0, 0, 0, 1, 0);
    chk_time("ticklap.stored", 0, 7);
    check("ticklap.showing", bus_if.showing_lap, 1);

    // Asynchronous reset in RECALL
    #2;
    reset = 0;
    #1;
    chk_time("arst", 0, 0);
    check("arst.showing", bus_if.showing_lap, 0);
    check("arst.count", bus_if.lap_count, 0);
    check("arst.blink", bus_if.blink_en, 0);
    @(negedge clk); reset = 1;
    cyc(1, 0, 0, 0, 0);
    check("post_rst.sec", bus_if.sec, 0);
    check("post_rst.running", bus_if.running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
